// File: rtl/time_uart_tx_pkg.sv
// Shared definitions for the time-of-day UART transmitter.
//   tx_state_t    : serialiser states (IDLE, START, DATA, STOP)
//   ASCII_ZERO    : ASCII code of '0'
//   MSG_BYTES     : bytes per time message (HHMMSS)
//   FRAME_BITS    : bits per 8N1 frame (start + 8 data + stop)
//   CLAMP_MAX     : largest value a two-digit field can show
//   bin_to_digits : binary 0..127 -> {tens, ones}, clamped to 99
package time_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int         MSG_BYTES  = 6;
    localparam int         FRAME_BITS = 10;
    localparam logic [6:0] CLAMP_MAX  = 7'd99;

    // Restoring division by 10 with weights 80/40/20/10; the remainder
    // after the last step is the ones digit (always < 10, fits 4 bits).
    function automatic logic [7:0] bin_to_digits(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = (v > CLAMP_MAX) ? CLAMP_MAX : v;
        t = 4'd0;
        if (r >= 7'd80) begin t[3] = 1'b1; r = r - 7'd80; end
        if (r >= 7'd40) begin t[2] = 1'b1; r = r - 7'd40; end
        if (r >= 7'd20) begin t[1] = 1'b1; r = r - 7'd20; end
        if (r >= 7'd10) begin t[0] = 1'b1; r = r - 7'd10; end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/time_uart_tx_if.sv
// Bus between the clock core and the time transmitter.
//   start              : send request (master -> slave)
//   hour/minute/second : binary time fields (master -> slave)
//   busy               : message in flight (slave -> master)
//   done               : one-cycle completion pulse (slave -> master)
//   uart_tx            : serial line towards the TX pin (slave -> master)
interface time_uart_tx_if;
    logic       start;
    logic [6:0] hour;
    logic [6:0] minute;
    logic [6:0] second;
    logic       busy;
    logic       done;
    logic       uart_tx;

    modport master (
        output start, hour, minute, second,
        input  busy, done, uart_tx
    );

    modport slave (
        input  start, hour, minute, second,
        output busy, done, uart_tx
    );
endinterface

// File: rtl/time_uart_tx_uart_byte_tx.sv
// Single-byte 8N1 serialiser with valid/ready handshake.
//   clk, rst   : clock, async active-high reset
//   valid/data : byte offered for transmission
//   ready      : byte is taken on this edge if valid (idle, or last
//                cycle of the stop bit so frames run back to back)
//   tx         : registered serial output, idles high
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | line high, waiting for valid
// ST_START | driving start bit (0) for BIT_CYCLES clocks
// ST_DATA  | driving data bits LSB first, 8 bits
// ST_STOP  | driving stop bit (1); may chain to next byte
module uart_byte_tx
    import time_uart_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CW        = ($clog2(BIT_CYCLES) < 13) ? 13 : $clog2(BIT_CYCLES);
    localparam int DATA_BITS = FRAME_BITS - 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        ready     = 1'b0;
        bit_end   = (cnt == CNT_LAST);

        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    state_n   = ST_START;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    shreg_n   = data;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    shreg_n   = shreg >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == BIT_LAST) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    ready = 1'b1;
                    cnt_n = '0;
                    if (valid) begin
                        state_n   = ST_START;
                        bit_idx_n = '0;
                        shreg_n   = data;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Output is registered from next-state values so the pin never glitches
        // and still changes exactly at the bit boundary.
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shreg_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: rtl/time_uart_tx.sv
// Sends the time of day as six ASCII digits "HHMMSS" over 8N1 UART.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of time_uart_tx_if (start, hour, minute,
//              second in; busy, done, uart_tx out)
// Parameters CLK_HZ and BAUD set clocks per bit as CLK_HZ/BAUD.
module time_uart_tx
    import time_uart_tx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic            clk,
    input  logic            rst,
    time_uart_tx_if.slave   bus
);

    localparam int         BIT_CYCLES = CLK_HZ / BAUD;
    localparam logic [2:0] BYTE_LAST  = 3'(MSG_BYTES - 1);

    logic [6:0] hour_q, minute_q, second_q;
    logic [2:0] byte_idx;
    logic       busy_q, done_q;

    logic [6:0] src_hour, src_minute, src_second;
    logic [7:0] hour_dig, minute_dig, second_dig;
    logic [2:0] sel;
    logic [3:0] digit;
    logic [7:0] byte_data;
    logic       byte_valid, byte_ready;
    logic       last_byte;

    // When idle the first byte is taken straight from the live inputs so the
    // start bit can begin the cycle after the accepting edge; once busy every
    // byte comes from the latched copy.
    assign src_hour   = busy_q ? hour_q   : bus.hour;
    assign src_minute = busy_q ? minute_q : bus.minute;
    assign src_second = busy_q ? second_q : bus.second;

    assign hour_dig   = bin_to_digits(src_hour);
    assign minute_dig = bin_to_digits(src_minute);
    assign second_dig = bin_to_digits(src_second);

    // byte_idx is the byte on the line; the byte offered is the next one.
    assign sel       = busy_q ? (byte_idx + 3'd1) : 3'd0;
    assign last_byte = (byte_idx == BYTE_LAST);

    always_comb begin
        digit = 4'd0;
        case (sel)
            3'd0:    digit = hour_dig[7:4];
            3'd1:    digit = hour_dig[3:0];
            3'd2:    digit = minute_dig[7:4];
            3'd3:    digit = minute_dig[3:0];
            3'd4:    digit = second_dig[7:4];
            default: digit = second_dig[3:0];
        endcase
    end

    assign byte_data  = ASCII_ZERO + {4'h0, digit};
    assign byte_valid = busy_q ? !last_byte : bus.start;

    // While busy the serialiser is never idle, so ready only rises in the
    // final cycle of a stop bit: that is the byte boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
            byte_idx <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (bus.start) begin
                    hour_q   <= bus.hour;
                    minute_q <= bus.minute;
                    second_q <= bus.second;
                    byte_idx <= '0;
                    busy_q   <= 1'b1;
                end
            end else if (byte_ready) begin
                if (last_byte) begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

    uart_byte_tx #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_byte_tx (
        .clk   (clk),
        .rst   (rst),
        .valid (byte_valid),
        .data  (byte_data),
        .ready (byte_ready),
        .tx    (bus.uart_tx)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: doc/time_uart_tx.md
# time_uart_tx

Serialises the current time of day as six ASCII decimal digits (HHMMSS) over a 9600-baud 8N1 UART line. It is the transmit-side counterpart of the time receiver: byte order, bit order and frame format match what that receiver samples, so a transmitter output looped to a receiver input reproduces the hour, minute and second values. It sits between the clock core, which supplies the binary hour/minute/second values and a send request, and the board UART TX pin.

## Interface

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate; BIT_CYCLES = CLK_HZ/BAUD (integer division, 5208 at defaults), clocks per bit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  send request, sampled on the rising edge of clk; acted on only in IDLE.
- hour  in  7  binary hours, 0–23 nominal.
- minute  in  7  binary minutes, 0–59 nominal.
- second  in  7  binary seconds, 0–59 nominal.
- busy  out  1  high from the cycle after an accepted start until the final stop bit ends.
- done  out  1  one-cycle pulse when a 6-byte message completes.
- uart_tx  out  1  serial line; idles high.

## Operation

- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_tx=1, busy=0.
  - start=1 latches hour/minute/second into internal registers and moves to START with byte index 0.
- Each field is converted to a tens digit and a ones digit. Values above 99 clamp to 99.
- Byte sequence: hour tens, hour ones, minute tens, minute ones, second tens, second ones. Each byte is 0x30 + digit.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held for exactly BIT_CYCLES clocks.
- START → DATA after BIT_CYCLES. DATA → STOP after 8 bits. STOP → START for the next byte with no idle gap, or → IDLE after byte 5.
- Input changes after acceptance have no effect on the message in flight.
- start while busy=1 is ignored. Requests are not queued.
- Reset values: uart_tx=1, busy=0, done=0, state IDLE, all counters 0. Reset takes effect immediately and asynchronously, including mid-frame; the partial frame is abandoned.

## Timing

- Accepting edge E: busy=1 and uart_tx=0 (start bit) from E+1.
- Bit k of byte n begins at E+1+(10n+k)·BIT_CYCLES.
- Whole message: 60·BIT_CYCLES clocks.
- At E+1+60·BIT_CYCLES:
  - state returns to IDLE.
  - busy=0 and done=1 for exactly that one cycle.
  - uart_tx stays 1.
- start=1 during the done cycle is accepted, giving back-to-back messages. The next start bit begins on the following cycle, so the line idles high for exactly one clock between messages.
- Baud counter: 13 bits minimum, counts 0..BIT_CYCLES−1, reloads at each bit boundary.
- Bit index: 3 bits. Byte index: 3 bits, values 0–5 only.
- Digit conversion is combinational from the latched registers: tens = v/10 via compare-subtract, ones = v − 10·tens, using 4-bit results.

## Structure

- Shared package holds:
  - state enum.
  - ASCII_ZERO = 8'h30.
  - MSG_BYTES = 6.
  - FRAME_BITS = 10.
  - clamp limit 99.
- One sub-module, uart_byte_tx:
  - Single-byte 8N1 serialiser with valid/ready handshake and BIT_CYCLES parameter; owns the baud counter, bit index and START/DATA/STOP states.
  - time_uart_tx owns latching, clamping, BCD/ASCII conversion, byte sequencing, busy and done.
- The bin-to-two-digit conversion is a package function, not a module.

## Test plan

Benches use CLK_HZ=160, BAUD=10, so BIT_CYCLES=16.

- Reset asserted mid-idle and released → uart_tx=1, busy=0, done=0 on every cycle.
- start with 12:34:56:
  - line decodes to 0x31 0x32 0x33 0x34 0x35 0x36 with no inter-byte gap.
  - busy high for 960 cycles.
  - done pulses once, 961 cycles after the accepting edge.
- 0:0:0 → six 0x30 bytes. 23:59:59 → 0x32 0x33 0x35 0x39 0x35 0x39. Each bit is exactly 16 cycles wide.
- hour=100, minute=127, second=99 → "999999".
- start re-pulsed while busy, and inputs changed mid-message → message unchanged, no second message. start held during the done cycle → second message begins after exactly one idle-high cycle.
- rst asserted mid-byte 2 → uart_tx=1 and busy=0 immediately. A fresh start after release sends a complete, correct 6-byte message.
